// File: rtl/seg7_scan_mux_pkg.sv
// Shared display parameters for the scan multiplexer and the downstream segment decoder.
// Holds the default digit count, the slot prescale and the digit-index width helper.
package seg7_scan_mux_pkg;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_PRESCALE   = 50000;

    // The index port is never narrower than one bit, even for a two-digit display.
    function automatic int idx_width(input int num_digits);
        return (num_digits <= 2) ? 1 : $clog2(num_digits);
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Slot prescaler: counts 0..PRESCALE-1 and flags the final cycle of each digit slot.
module seg7_prescaler
    import seg7_scan_mux_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    output logic slot_tick
);

    localparam int CW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        slot_tick = (count_q == LAST);
        count_d   = slot_tick ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with leading-zero suppression.
// Emits the selected nibble, decimal point and anode enables; segment decoding happens downstream.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int PRESCALE   = DEF_PRESCALE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [4*NUM_DIGITS-1:0]         value_in,
    input  logic                            load,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    input  logic                            lz_en,
    output logic [3:0]                      digit_hex,
    output logic                            dp_n,
    output logic [NUM_DIGITS-1:0]           an_n,
    output logic [idx_width(NUM_DIGITS)-1:0] digit_idx,
    output logic                            slot_tick
);

    localparam int IW = idx_width(NUM_DIGITS);

    logic [IW-1:0]           idx_q,   idx_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dp_q,    dp_d;
    logic                    lz_q,    lz_d;
    logic [NUM_DIGITS-1:0]   an_q,    an_d;
    logic [3:0]              hex_q,   hex_d;
    logic                    dpn_q,   dpn_d;
    logic [NUM_DIGITS-1:0]   blank_d;

    seg7_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .slot_tick (slot_tick)
    );

    always_comb begin
        value_d = load ? value_in : value_q;
        dp_d    = load ? dp_in    : dp_q;
        lz_d    = load ? lz_en    : lz_q;
        idx_d   = idx_q;
        if (slot_tick) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // A digit stays blank only while every nibble from the top down to it is zero
    // and no decimal point is requested at or above it.
    always_comb begin : blank_scan
        logic lead;
        lead    = lz_d;
        blank_d = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead       = lead && (value_d[4*i +: 4] == 4'h0) && !dp_d[i];
            blank_d[i] = lead && (i != 0);
        end
    end

    // Outputs are computed from the post-edge index and display registers so a
    // load coinciding with a slot advance shows the new value at the new index.
    always_comb begin
        an_d  = '1;
        hex_d = 4'h0;
        dpn_d = 1'b1;
        if (!blank_d[idx_d]) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_d);
            hex_d = value_d[4*idx_d +: 4];
            dpn_d = ~dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            value_q <= '0;
            dp_q    <= '0;
            lz_q    <= 1'b0;
            an_q    <= '1;
            hex_q   <= 4'h0;
            dpn_q   <= 1'b1;
        end else begin
            idx_q   <= idx_d;
            value_q <= value_d;
            dp_q    <= dp_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            hex_q   <= hex_d;
            dpn_q   <= dpn_d;
        end
    end

    assign an_n      = an_q;
    assign digit_hex = hex_q;
    assign dp_n      = dpn_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with four digits and a four-cycle slot.
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int PS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value_in = '0;
    logic          load = 1'b0;
    logic [3:0]    dp_in = '0;
    logic          lz_en = 1'b0;
    logic [3:0]    digit_hex;
    logic          dp_n;
    logic [3:0]    an_n;
    logic [1:0]    digit_idx;
    logic          slot_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] hex;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seg7_scan_mux #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .load      (load),
        .dp_in     (dp_in),
        .lz_en     (lz_en),
        .digit_hex (digit_hex),
        .dp_n      (dp_n),
        .an_n      (an_n),
        .digit_idx (digit_idx),
        .slot_tick (slot_tick)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d, input logic lz);
        value_in = v;
        dp_in    = d;
        lz_en    = lz;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Returns at the negedge of the cycle in which slot_tick is high.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2*PS + 2 && !seen; k++) begin
            @(negedge clk);
            if (slot_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_tick: slot_tick got none, want a pulse within %0d cycles", 2*PS + 2);
        end
    endtask

    // Leaves the bench at the tick that ends the digit-3 slot, so the next edge shows digit 0.
    task automatic align_to_digit0();
        repeat (ND) wait_tick();
    endtask

    task automatic push_slot(input int idx, input logic [3:0] hex, input logic dpn, input logic blank);
        exp_t e;
        e.idx = 2'(idx);
        e.an  = blank ? 4'b1111 : ~(4'b0001 << idx);
        e.hex = blank ? 4'h0 : hex;
        e.dp  = blank ? 1'b1 : dpn;
        repeat (PS) sb.push_back(e);
    endtask

    task automatic test_reset();
        do_reset();
        load_val(16'h1A3F, 4'b0000, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst      = 1'b1;
        value_in = 16'hFFFF;
        lz_en    = 1'b1;
        load     = 1'b1;
        #1;
        n_cmp++;
        if (an_n !== 4'b1111) begin n_bad++; $display("FAIL reset_an: got %b want 1111", an_n); end
        n_cmp++;
        if (digit_hex !== 4'h0) begin n_bad++; $display("FAIL reset_hex: got %h want 0", digit_hex); end
        n_cmp++;
        if (dp_n !== 1'b1) begin n_bad++; $display("FAIL reset_dp: got %b want 1", dp_n); end
        n_cmp++;
        if (digit_idx !== 2'd0 || slot_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idx_tick: got idx=%0d tick=%b want idx=0 tick=0", digit_idx, slot_tick);
        end
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= PS; c++) begin
            @(negedge clk);
            n_cmp++;
            if (slot_tick !== (c == PS - 1)) begin
                n_bad++;
                $display("FAIL release_tick[%0d]: got %b want %b", c, slot_tick, (c == PS - 1));
            end
            if (c == 1) begin
                n_cmp++;
                if ({an_n, digit_hex, dp_n, digit_idx} !== {4'b1110, 4'h0, 1'b1, 2'd0}) begin
                    n_bad++;
                    $display("FAIL release_first: got an_n=%b hex=%h dp_n=%b idx=%0d want 1110 0 1 0",
                             an_n, digit_hex, dp_n, digit_idx);
                end
            end
            if (c == PS) begin
                n_cmp++;
                if ({an_n, digit_hex, digit_idx} !== {4'b1101, 4'h0, 2'd1}) begin
                    n_bad++;
                    $display("FAIL release_advance: got an_n=%b hex=%h idx=%0d want 1101 0 1",
                             an_n, digit_hex, digit_idx);
                end
            end
        end
    endtask

    task automatic test_scan();
        exp_t e, obs;
        do_reset();
        load_val(16'h1A3F, 4'b0000, 1'b0);
        push_slot(0, 4'hF, 1'b1, 1'b0);
        push_slot(1, 4'h3, 1'b1, 1'b0);
        push_slot(2, 4'hA, 1'b1, 1'b0);
        push_slot(3, 4'h1, 1'b1, 1'b0);
        push_slot(0, 4'hF, 1'b1, 1'b0);
        align_to_digit0();
        while (sb.size() > 0) begin
            @(negedge clk);
            e   = sb.pop_front();
            obs = '{an: an_n, hex: digit_hex, dp: dp_n, idx: digit_idx};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL scan: got an_n=%b hex=%h dp_n=%b idx=%0d want an_n=%b hex=%h dp_n=%b idx=%0d",
                         obs.an, obs.hex, obs.dp, obs.idx, e.an, e.hex, e.dp, e.idx);
            end
        end
    endtask

    task automatic test_suppress();
        exp_t e, obs;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            if (pass == 0) begin
                load_val(16'h0042, 4'b0000, 1'b1);
                push_slot(0, 4'h2, 1'b1, 1'b0);
                push_slot(1, 4'h4, 1'b1, 1'b0);
                push_slot(2, 4'h0, 1'b1, 1'b1);
                push_slot(3, 4'h0, 1'b1, 1'b1);
            end else begin
                load_val(16'h0000, 4'b0000, 1'b1);
                push_slot(0, 4'h0, 1'b1, 1'b0);
                push_slot(1, 4'h0, 1'b1, 1'b1);
                push_slot(2, 4'h0, 1'b1, 1'b1);
                push_slot(3, 4'h0, 1'b1, 1'b1);
            end
            align_to_digit0();
            while (sb.size() > 0) begin
                @(negedge clk);
                e   = sb.pop_front();
                obs = '{an: an_n, hex: digit_hex, dp: dp_n, idx: digit_idx};
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL suppress%0d: got an_n=%b hex=%h dp_n=%b idx=%0d want an_n=%b hex=%h dp_n=%b idx=%0d",
                             pass, obs.an, obs.hex, obs.dp, obs.idx, e.an, e.hex, e.dp, e.idx);
                end
            end
        end
    endtask

    task automatic test_dp_override();
        exp_t e, obs;
        do_reset();
        load_val(16'h0005, 4'b0100, 1'b1);
        push_slot(0, 4'h5, 1'b1, 1'b0);
        push_slot(1, 4'h0, 1'b1, 1'b0);
        push_slot(2, 4'h0, 1'b0, 1'b0);
        push_slot(3, 4'h0, 1'b1, 1'b1);
        align_to_digit0();
        while (sb.size() > 0) begin
            @(negedge clk);
            e   = sb.pop_front();
            obs = '{an: an_n, hex: digit_hex, dp: dp_n, idx: digit_idx};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL dp_override: got an_n=%b hex=%h dp_n=%b idx=%0d want an_n=%b hex=%h dp_n=%b idx=%0d",
                         obs.an, obs.hex, obs.dp, obs.idx, e.an, e.hex, e.dp, e.idx);
            end
        end
    endtask

    task automatic test_coincide();
        exp_t e, obs;
        do_reset();
        wait_tick();
        value_in = 16'hBEEF;
        dp_in    = 4'b0000;
        lz_en    = 1'b0;
        load     = 1'b1;
        push_slot(1, 4'hE, 1'b1, 1'b0);
        push_slot(2, 4'hE, 1'b1, 1'b0);
        push_slot(3, 4'hB, 1'b1, 1'b0);
        @(posedge clk);
        #1 load = 1'b0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e   = sb.pop_front();
            obs = '{an: an_n, hex: digit_hex, dp: dp_n, idx: digit_idx};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL coincide: got an_n=%b hex=%h dp_n=%b idx=%0d want an_n=%b hex=%h dp_n=%b idx=%0d",
                         obs.an, obs.hex, obs.dp, obs.idx, e.an, e.hex, e.dp, e.idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, obs;
        do_reset();
        load_val(16'h1111, 4'b1111, 1'b1);
        load_val(16'h2C02, 4'b0000, 1'b1);
        push_slot(0, 4'h2, 1'b1, 1'b0);
        push_slot(1, 4'h0, 1'b1, 1'b0);
        push_slot(2, 4'hC, 1'b1, 1'b0);
        push_slot(3, 4'h2, 1'b1, 1'b0);
        align_to_digit0();
        while (sb.size() > 0) begin
            @(negedge clk);
            e   = sb.pop_front();
            obs = '{an: an_n, hex: digit_hex, dp: dp_n, idx: digit_idx};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL back_to_back: got an_n=%b hex=%h dp_n=%b idx=%0d want an_n=%b hex=%h dp_n=%b idx=%0d",
                         obs.an, obs.hex, obs.dp, obs.idx, e.an, e.hex, e.dp, e.idx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_suppress();
        test_dp_override();
        test_coincide();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed display digits (2..8).
REQ-002 SHALL have parameter PRESCALE, default 50000, clk cycles per digit slot (>=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port value_in  input  4*NUM_DIGITS  hex value; nibble i is digit i, digit 0 rightmost.
REQ-006 SHALL have port load  input  1  one-cycle strobe: capture value_in, dp_in and lz_en.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-008 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-009 SHALL have port digit_hex  output  4  nibble of the selected digit, to the downstream hex-to-segment decoder.
REQ-010 SHALL have port dp_n  output  1  decimal point of the selected digit, active-low.
REQ-011 SHALL have port an_n  output  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-012 SHALL have port digit_idx  output  clog2(NUM_DIGITS)  index of the selected digit.
REQ-013 SHALL have port slot_tick  output  1  one-cycle pulse when the slot advances.

Function
REQ-014 SHALL run a prescaler counting 0..PRESCALE-1, wrapping to 0; slot_tick = 1 combinationally in the cycle where count == PRESCALE-1.
REQ-015 SHALL advance the digit index by 1 on each edge where slot_tick is 1, wrapping NUM_DIGITS-1 -> 0.
REQ-016 SHALL hold display registers (value, dp, lz_en) that update only on edges with load = 1; between loads the display is static.
REQ-017 SHALL register digit_hex, dp_n, an_n, digit_idx: at edge k they reflect the index and display registers as updated at edge k (latency one edge from load or slot advance).
REQ-018 SHALL, when load and slot_tick coincide, apply both: the outputs after that edge show the new index with the newly loaded value.
REQ-019 SHALL mark digit i blank when lz_en_reg = 1, i != 0, and nibbles NUM_DIGITS-1 down to i are all zero; digit 0 never blank.
REQ-020 SHALL, for a blank selected digit, drive an_n all-ones, digit_hex = 0, dp_n = 1; the slot still consumes its full PRESCALE cycles.
REQ-021 SHALL, for a non-blank selected digit, drive an_n with only bit digit_idx low, digit_hex = nibble digit_idx, dp_n = ~dp_reg[digit_idx].
REQ-022 SHALL not blank a digit whose dp_reg bit is 1 (dp overrides suppression for that digit and all lower ones).
REQ-023 SHALL ignore load during reset; no other handshake exists (load is never back-pressured).

Reset
REQ-024 SHALL, while rst = 1, asynchronously force prescaler = 0, digit index = 0, value_reg = 0, dp_reg = 0, lz_en_reg = 0.
REQ-025 SHALL, while rst = 1, force an_n = all-ones, digit_hex = 0, dp_n = 1, digit_idx = 0, slot_tick = 0.
REQ-026 SHALL, after rst deasserts, produce the first slot_tick PRESCALE cycles later; an_n drives digit 0 (value 0) from the first edge after release.
REQ-027 SHALL, on reset mid-slot, discard the partial count and all display registers.

Structure
REQ-028 SHALL take NUM_DIGITS/PRESCALE defaults and the index-width function from the shared display package used by the segment decoder.
REQ-029 SHALL contain one natural sub-module, seg7_prescaler (parameterised counter producing slot_tick); blanking logic stays inline.
REQ-030 SHALL contain no segment decoding; digit_hex feeds the existing decoder stage unchanged.

Verification (PRESCALE=4, NUM_DIGITS=4)
REQ-031 SHALL check reset: rst high mid-slot -> an_n=1111, digit_hex=0, dp_n=1 immediately; first slot_tick 4 cycles after release.
REQ-032 SHALL check scanning: load 16'h1A3F, lz_en=0 -> digit_hex sequence F,3,A,1,F with an_n 1110,1101,1011,0111,1110, each held 4 cycles.
REQ-033 SHALL check suppression: load 16'h0042, lz_en=1 -> digits 3,2 blank (an_n=1111), digits 1,0 show 4,2; load 16'h0000 -> only digit 0 shows 0.
REQ-034 SHALL check dp override: load 16'h0005, dp_in=4'b0100, lz_en=1 -> digit 2 shows 0 with dp_n=0, digit 3 blank.
REQ-035 SHALL check coincidence: load 16'hBEEF on the slot_tick cycle from digit 0 -> next edge shows digit_idx=1, digit_hex=E.
